// File: rtl/m_dm_unit.sv
// M-stage data memory unit.
//
// A DEPTH-word array addressed by M_ALU_result. It decodes the load/store
// opcode from M_command[31:26] and serves these instructions:
//   loads:  lw, lh, lhu, lb, lbu
//   stores: sw, sh, sb
//
// Reads are combinational. Stores commit at posedge clk as a byte-enabled
// read-modify-write. A load in the same cycle therefore sees pre-store data.
//
// Misaligned or out-of-range accesses raise M_DM_err. When that happens the
// store is dropped, and a load returns 0.
//
// Optional build macro:
//   DM_TRACE_EN  prints one trace line for each committed store.
//
// Ports:
//   clk           clock; all state changes on posedge
//   res           synchronous active-high reset; clears the whole array
//   M_command     M-stage instruction; bits [31:26] are the opcode
//   M_PC          M-stage PC; used only by the store trace
//   M_ALU_result  effective byte address
//   M_RD2         store data, already forwarded
//   M_DM_out      load result, sign/zero extended to 32 bits
//   M_DM_err      misaligned or out-of-range load/store
module m_dm_unit #(
  parameter int unsigned DEPTH = 3072
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] M_command,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_ALU_result,
  input  logic [31:0] M_RD2,
  output logic [31:0] M_DM_out,
  output logic        M_DM_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpSw  = 6'h2B;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSb  = 6'h28;

  logic [31:0] mem_q [DEPTH];

  logic [5:0]  opcode;
  logic [29:0] word_idx;
  logic [1:0]  byte_off;
  logic        is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb;
  logic        is_load, is_store;
  logic        misaligned, in_range, access_err, store_commit;
  logic [31:0] rd_word, wr_data, merged;
  logic [3:0]  byte_en;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;

  assign opcode   = M_command[31:26];
  assign word_idx = M_ALU_result[31:2];
  assign byte_off = M_ALU_result[1:0];

  assign is_lw  = (opcode == OpLw);
  assign is_lh  = (opcode == OpLh);
  assign is_lhu = (opcode == OpLhu);
  assign is_lb  = (opcode == OpLb);
  assign is_lbu = (opcode == OpLbu);
  assign is_sw  = (opcode == OpSw);
  assign is_sh  = (opcode == OpSh);
  assign is_sb  = (opcode == OpSb);

  assign is_load  = is_lw | is_lh | is_lhu | is_lb | is_lbu;
  assign is_store = is_sw | is_sh | is_sb;

  assign misaligned = ((is_lw | is_sw) && (byte_off != 2'b00)) ||
                      ((is_lh | is_lhu | is_sh) && byte_off[0]);
  assign in_range   = ({2'b00, word_idx} < DEPTH);

  // Bubbles and unrelated opcodes never report an error.
  assign access_err   = (is_load | is_store) & (misaligned | ~in_range);
  assign store_commit = is_store & ~access_err;

  // Guard the array read so out-of-range indices never reach the array.
  assign rd_word = in_range ? mem_q[word_idx[AW-1:0]] : '0;
  assign rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
  assign rd_byte = rd_word[8*byte_off +: 8];

  always_comb begin
    M_DM_out = '0;
    if (!access_err) begin
      if (is_lw)  M_DM_out = rd_word;
      if (is_lh)  M_DM_out = {{16{rd_half[15]}}, rd_half};
      if (is_lhu) M_DM_out = {16'h0000, rd_half};
      if (is_lb)  M_DM_out = {{24{rd_byte[7]}}, rd_byte};
      if (is_lbu) M_DM_out = {24'h000000, rd_byte};
    end
  end

  assign M_DM_err = access_err;

  // Replicate the store data across the word, then choose lanes with byte_en.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = M_RD2;
    if (is_sw) begin
      byte_en = 4'b1111;
    end else if (is_sh) begin
      byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{M_RD2[15:0]}};
    end else if (is_sb) begin
      byte_en = 4'b0001 << byte_off;
      wr_data = {4{M_RD2[7:0]}};
    end
  end

  always_comb begin
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (store_commit) begin
      mem_q[word_idx[AW-1:0]] <= merged;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!res && store_commit) begin
      $display("%0t@%08h: *%08h <= %08h", $time, M_PC, {M_ALU_result[31:2], 2'b00}, merged);
    end
  end
`else
  // Without tracing, M_PC has no consumer.
  logic unused_pc;
  assign unused_pc = ^M_PC;
`endif

endmodule

// File: tb/tb_m_dm_unit.sv
module tb_m_dm_unit;

  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpSw  = 6'h2B;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSb  = 6'h28;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] M_command, M_PC, M_ALU_result, M_RD2;
  logic [31:0] M_DM_out;
  logic        M_DM_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  m_dm_unit #(.DEPTH(3072)) dut (
    .clk          (clk),
    .res          (res),
    .M_command    (M_command),
    .M_PC         (M_PC),
    .M_ALU_result (M_ALU_result),
    .M_RD2        (M_RD2),
    .M_DM_out     (M_DM_out),
    .M_DM_err     (M_DM_err)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_out;
    logic [31:0] exp_out;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [5:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic chk_out,
                     input logic [31:0] exp_out, input logic exp_err);
    vec_t v;
    v.rst = rst; v.op = op; v.pc = 32'h0000_1000; v.addr = addr; v.wdata = wdata;
    v.chk_out = chk_out; v.exp_out = exp_out; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Drive on negedge, sample #1 later (well before posedge), commit at posedge.
  task automatic step(input string name, input logic rst, input logic [5:0] op,
                      input logic [31:0] pc, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic chk_out,
                      input logic [31:0] exp_out, input logic exp_err);
    @(negedge clk);
    res = rst; M_command = {op, 26'h0}; M_PC = pc; M_ALU_result = addr; M_RD2 = wdata;
    #1;
    checks++;
    if (M_DM_err !== exp_err || (chk_out && M_DM_out !== exp_out)) begin
      failures++;
      $display("FAIL %s: out=%08h err=%0b required out=%08h err=%0b (out checked=%0b)",
               name, M_DM_out, M_DM_err, exp_out, exp_err, chk_out);
    end
    @(posedge clk);
  endtask

  initial begin
    res = 1'b0; M_command = '0; M_PC = '0; M_ALU_result = '0; M_RD2 = '0;

    // Reset, then loads of the cleared array at both ends.
    add(1, OpLw, 32'h0000, 0, 0, 0, 0);
    add(0, OpLw, 32'h0000, 0, 1, 32'h0000_0000, 0);
    add(0, OpLw, 32'h2FFC, 0, 1, 32'h0000_0000, 0);
    // Word store followed by a byte merge and extension checks.
    add(0, OpSw, 32'h0010, 32'h1234_5678, 1, 0, 0);
    add(0, OpSb, 32'h0011, 32'h0000_00AB, 1, 0, 0);
    add(0, OpLw, 32'h0010, 0, 1, 32'h1234_AB78, 0);
    add(0, OpLb, 32'h0011, 0, 1, 32'hFFFF_FFAB, 0);
    add(0, OpLbu, 32'h0011, 0, 1, 32'h0000_00AB, 0);
    // Halfword store into the upper half.
    add(0, OpSh, 32'h0022, 32'h0000_8001, 1, 0, 0);
    add(0, OpLh, 32'h0022, 0, 1, 32'hFFFF_8001, 0);
    add(0, OpLhu, 32'h0022, 0, 1, 32'h0000_8001, 0);
    add(0, OpLw, 32'h0020, 0, 1, 32'h8001_0000, 0);
    // Faulting accesses: misaligned, out of range; array must stay unchanged.
    add(0, OpSw, 32'h0013, 32'hCAFE_F00D, 1, 0, 1);
    add(0, OpSw, 32'h3000, 32'hCAFE_F00D, 1, 0, 1);
    add(0, OpLw, 32'h0010, 0, 1, 32'h1234_AB78, 0);
    add(0, OpLw, 32'h0000, 0, 1, 32'h0000_0000, 0);
    add(0, OpLw, 32'h2FFC, 0, 1, 32'h0000_0000, 0);
    add(0, OpLh, 32'h0021, 0, 1, 32'h0000_0000, 1);
    add(0, OpLw, 32'h3000, 0, 1, 32'h0000_0000, 1);
    add(0, OpLbu, 32'h3001, 0, 1, 32'h0000_0000, 1);
    // Back-to-back stores, then assorted lane selects.
    add(0, OpSw, 32'h0050, 32'h1122_3344, 1, 0, 0);
    add(0, OpSw, 32'h0054, 32'h5566_7788, 1, 0, 0);
    add(0, OpLw, 32'h0050, 0, 1, 32'h1122_3344, 0);
    add(0, OpLw, 32'h0054, 0, 1, 32'h5566_7788, 0);
    add(0, OpLb, 32'h0053, 0, 1, 32'h0000_0011, 0);
    add(0, OpLh, 32'h0056, 0, 1, 32'h0000_5566, 0);
    add(0, OpLbu, 32'h0054, 0, 1, 32'h0000_0088, 0);
    add(0, OpLb, 32'h0054, 0, 1, 32'hFFFF_FF88, 0);
    add(0, OpSh, 32'h0050, 32'hFFFF_ABCD, 1, 0, 0);
    add(0, OpLw, 32'h0050, 0, 1, 32'h1122_ABCD, 0);
    add(0, OpSb, 32'h0052, 32'h0000_0099, 1, 0, 0);
    add(0, OpLw, 32'h0050, 0, 1, 32'h1199_ABCD, 0);
    // Store during reset: reset wins and clears everything.
    add(1, OpSw, 32'h0040, 32'hDEAD_BEEF, 0, 0, 0);
    add(0, OpLw, 32'h0040, 0, 1, 32'h0000_0000, 0);
    add(0, OpLw, 32'h0050, 0, 1, 32'h0000_0000, 0);
    // Bubble and unrelated opcode at faulting addresses: no error, no write.
    add(0, 6'h00, 32'h0013, 32'hFFFF_FFFF, 1, 0, 0);
    add(0, 6'h2A, 32'h3001, 32'hFFFF_FFFF, 1, 0, 0);
    add(0, OpLw, 32'h0010, 0, 1, 32'h0000_0000, 0);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].pc, vecs[i].addr,
           vecs[i].wdata, vecs[i].chk_out, vecs[i].exp_out, vecs[i].exp_err);
    end

    // Traced store (prints a line only when tracing is built in).
    step("trace_sw", 0, OpSw, 32'h0000_3008, 32'h0004, 32'h0000_00FF, 1, 0, 0);
    step("trace_lw", 0, OpLw, 32'h0, 32'h0004, 0, 1, 32'h0000_00FF, 0);

    // Store into the last word, then reset asserted together with another store.
    step("last_sw", 0, OpSw, 32'h0, 32'h2FFC, 32'hA5A5_5A5A, 1, 0, 0);
    step("last_lw", 0, OpLw, 32'h0, 32'h2FFC, 0, 1, 32'hA5A5_5A5A, 0);
    step("rst_sw", 1, OpSw, 32'h0, 32'h0060, 32'h0BAD_F00D, 0, 0, 0);
    step("rst_lw60", 0, OpLw, 32'h0, 32'h0060, 0, 1, 32'h0000_0000, 0);
    step("rst_lwlast", 0, OpLw, 32'h0, 32'h2FFC, 0, 1, 32'h0000_0000, 0);
    step("rst_lw4", 0, OpLw, 32'h0, 32'h0004, 0, 1, 32'h0000_0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
